// File: rtl/huc6270_pkg.sv
// Shared HuC6270 VDC host-port types: port selects, register numbers, request
// opcodes and the per-phase descriptor used by the bus master.
package huc6270_pkg;

    typedef enum logic [1:0] {
        A_STATUS_ADDR_REG = 2'b00,
        A_DATA_LSB        = 2'b10,
        A_DATA_MSB        = 2'b11
    } a_sel_t;

    typedef logic [4:0] addr_reg_t;

    typedef enum logic [1:0] {
        OP_SEL       = 2'd0,
        OP_WR_REG    = 2'd1,
        OP_RD_REG    = 2'd2,
        OP_RD_STATUS = 2'd3
    } op_t;

    localparam addr_reg_t REG_MAWR  = 5'h00;
    localparam addr_reg_t REG_MARR  = 5'h01;
    localparam addr_reg_t REG_VRR   = 5'h02;
    localparam addr_reg_t REG_VWR   = 5'h02;
    localparam addr_reg_t REG_CR    = 5'h05;
    localparam addr_reg_t REG_RCR   = 5'h06;
    localparam addr_reg_t REG_BXR   = 5'h07;
    localparam addr_reg_t REG_BYR   = 5'h08;
    localparam addr_reg_t REG_MWR   = 5'h09;
    localparam addr_reg_t REG_HSR   = 5'h0A;
    localparam addr_reg_t REG_HDR   = 5'h0B;
    localparam addr_reg_t REG_VSR   = 5'h0C;
    localparam addr_reg_t REG_VDR   = 5'h0D;
    localparam addr_reg_t REG_VCR   = 5'h0E;
    localparam addr_reg_t REG_DCR   = 5'h0F;
    localparam addr_reg_t REG_SOUR  = 5'h10;
    localparam addr_reg_t REG_DESR  = 5'h11;
    localparam addr_reg_t REG_LENR  = 5'h12;
    localparam addr_reg_t REG_DVSSR = 5'h13;

    localparam int MAX_PHASES = 3;

    // Bus-cycle states; GAP belongs to the sequencer, the rest to vdc_bus_cycle.
    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_GAP
    } bus_st_t;

    typedef enum logic [1:0] {
        SQ_IDLE, SQ_RUN, SQ_GAP
    } seq_st_t;

    typedef struct packed {
        logic   rd;
        a_sel_t a;
        logic [7:0] d;
    } phase_t;

endpackage

// File: rtl/vdc_bus_master_if.sv
// Request/response channel plus VDC host-port pins; master = bus master side.
interface vdc_bus_master_if;
    import huc6270_pkg::*;

    logic       req_valid;
    logic       req_ready;
    op_t        req_op;
    addr_reg_t  req_reg;
    logic [15:0] req_wdata;
    logic       rsp_valid;
    logic [15:0] rsp_rdata;
    logic [7:0] rsp_status;

    logic       CS_n;
    logic       RD_n;
    logic       WR_n;
    a_sel_t     A;
    logic [7:0] DO;
    logic [7:0] DI;
    logic       BUSY_n;

    modport master (
        input  req_valid, req_op, req_reg, req_wdata, DI, BUSY_n,
        output req_ready, rsp_valid, rsp_rdata, rsp_status, CS_n, RD_n, WR_n, A, DO
    );

    modport slave (
        output req_valid, req_op, req_reg, req_wdata, DI, BUSY_n,
        input  req_ready, rsp_valid, rsp_rdata, rsp_status, CS_n, RD_n, WR_n, A, DO
    );

endinterface

// File: rtl/vdc_bus_cycle.sv
// One VDC byte cycle: SETUP -> STROBE (stretched by BUSY_n) -> HOLD, with DI
// captured on the edge that ends the strobe.
module vdc_bus_cycle
    import huc6270_pkg::*;
#(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start_i,
    input  phase_t     phase_i,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic       cs_n_o,
    output logic       rd_n_o,
    output logic       wr_n_o,
    output a_sel_t     a_o,
    output logic [7:0] do_o,
    input  logic [7:0] di_i,
    input  logic       busy_n_i
);

    bus_st_t    st_q, st_d;
    logic [7:0] cnt_q, cnt_d;
    phase_t     ph_q;
    logic [7:0] rdata_q;
    logic       cap;

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q + 8'd1;
        done_o = 1'b0;
        cap    = 1'b0;
        case (st_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_i) st_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (cnt_q == 8'(SETUP_CYCLES - 1)) begin
                    st_d  = ST_STROBE;
                    cnt_d = '0;
                end
            end
            ST_STROBE: begin
                if (cnt_q >= 8'(STROBE_CYCLES - 1)) begin
                    // minimum width met: counter parks while BUSY_n stretches
                    cnt_d = cnt_q;
                    if (busy_n_i) begin
                        st_d  = ST_HOLD;
                        cnt_d = '0;
                        cap   = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'(HOLD_CYCLES - 1)) begin
                    st_d   = ST_IDLE;
                    cnt_d  = '0;
                    done_o = 1'b1;
                end
            end
            default: begin
                st_d  = ST_IDLE;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_q    <= ST_IDLE;
            cnt_q   <= '0;
            ph_q    <= '0;
            rdata_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            if (st_q == ST_IDLE && start_i) ph_q <= phase_i;
            if (cap && ph_q.rd) rdata_q <= di_i;
        end
    end

    assign cs_n_o  = (st_q == ST_IDLE);
    assign rd_n_o  = !((st_q == ST_STROBE) && ph_q.rd);
    assign wr_n_o  = !((st_q == ST_STROBE) && !ph_q.rd);
    assign a_o     = ph_q.a;
    assign do_o    = ph_q.d;
    assign rdata_o = rdata_q;

endmodule

// File: rtl/vdc_bus_master.sv
// HuC6270 host-port initiator: expands a 16-bit register request into up to three
// byte cycles, caches the selected register, and synchronizes IRQ_n.
module vdc_bus_master
    import huc6270_pkg::*;
#(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1,
    parameter bit CACHE_ADDR    = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    vdc_bus_master_if.master bus,
    input  logic             IRQ_n,
    output logic             irq
);

    seq_st_t   sq_q, sq_d;
    op_t       op_q;
    addr_reg_t reg_q;
    phase_t [MAX_PHASES-1:0] list_q, list_d;
    logic [1:0] nph_q, nph_d, idx_q, idx_d;
    addr_reg_t cache_q;
    logic      cache_vld_q;
    logic      rdy_en_q;
    logic [7:0] lsb_q;
    logic      rsp_valid_q;
    logic [15:0] rsp_rdata_q;
    logic [7:0] rsp_status_q;
    logic      irq_s_q, irq_q;

    logic      accept, hit, last_ph, cur_rd, bc_start, bc_done;
    a_sel_t    cur_a;
    phase_t    bc_phase, sel_ph, lo_ph, hi_ph;
    logic [7:0] bc_rdata;
    logic      rd_op;

    assign bus.req_ready = rdy_en_q && (sq_q == SQ_IDLE);
    assign accept  = bus.req_valid && bus.req_ready;
    assign hit     = CACHE_ADDR && cache_vld_q && (bus.req_reg == cache_q);
    assign cur_rd  = list_q[idx_q].rd;
    assign cur_a   = list_q[idx_q].a;
    assign last_ph = (idx_q == nph_q - 2'd1);

    // Phase list built from the live request; only latched on acceptance.
    always_comb begin
        rd_op  = (bus.req_op == OP_RD_REG);
        sel_ph = '{rd: 1'b0, a: A_STATUS_ADDR_REG, d: {3'b000, bus.req_reg}};
        lo_ph  = '{rd: rd_op, a: A_DATA_LSB, d: rd_op ? 8'h00 : bus.req_wdata[7:0]};
        hi_ph  = '{rd: rd_op, a: A_DATA_MSB, d: rd_op ? 8'h00 : bus.req_wdata[15:8]};
        list_d = '0;
        nph_d  = 2'd1;
        case (bus.req_op)
            OP_SEL: list_d[0] = sel_ph;
            OP_WR_REG, OP_RD_REG: begin
                if (hit) begin
                    list_d[0] = lo_ph;
                    list_d[1] = hi_ph;
                    nph_d     = 2'd2;
                end else begin
                    list_d[0] = sel_ph;
                    list_d[1] = lo_ph;
                    list_d[2] = hi_ph;
                    nph_d     = 2'd3;
                end
            end
            OP_RD_STATUS: list_d[0] = '{rd: 1'b1, a: A_STATUS_ADDR_REG, d: 8'h00};
            default: ;
        endcase
    end

    always_comb begin
        sq_d     = sq_q;
        idx_d    = idx_q;
        bc_start = 1'b0;
        case (sq_q)
            SQ_IDLE: begin
                if (accept) begin
                    sq_d     = SQ_RUN;
                    idx_d    = 2'd0;
                    bc_start = 1'b1;
                end
            end
            SQ_RUN: begin
                if (bc_done) begin
                    if (last_ph) begin
                        sq_d = SQ_IDLE;
                    end else begin
                        sq_d  = SQ_GAP;
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            SQ_GAP: begin
                sq_d     = SQ_RUN;
                bc_start = 1'b1;
            end
            default: sq_d = SQ_IDLE;
        endcase
    end

    assign bc_phase = (sq_q == SQ_IDLE) ? list_d[0] : list_q[idx_q];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sq_q         <= SQ_IDLE;
            idx_q        <= '0;
            op_q         <= OP_SEL;
            reg_q        <= '0;
            list_q       <= '0;
            nph_q        <= 2'd1;
            cache_q      <= '0;
            cache_vld_q  <= 1'b0;
            rdy_en_q     <= 1'b0;
            lsb_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_status_q <= '0;
        end else begin
            sq_q        <= sq_d;
            idx_q       <= idx_d;
            rdy_en_q    <= 1'b1;
            rsp_valid_q <= 1'b0;
            if (accept) begin
                op_q   <= bus.req_op;
                reg_q  <= bus.req_reg;
                list_q <= list_d;
                nph_q  <= nph_d;
            end
            if (sq_q == SQ_RUN && bc_done) begin
                if (!cur_rd && cur_a == A_STATUS_ADDR_REG) begin
                    cache_q     <= reg_q;
                    cache_vld_q <= 1'b1;
                end
                if (cur_rd && cur_a == A_DATA_LSB) lsb_q <= bc_rdata;
                if (last_ph) begin
                    rsp_valid_q <= 1'b1;
                    if (op_q == OP_RD_REG)    rsp_rdata_q  <= {bc_rdata, lsb_q};
                    if (op_q == OP_RD_STATUS) rsp_status_q <= bc_rdata;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_s_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            irq_s_q <= ~IRQ_n;
            irq_q   <= irq_s_q;
        end
    end

    logic       cs_n, rd_n, wr_n;
    a_sel_t     a_pin;
    logic [7:0] do_pin;

    vdc_bus_cycle #(
        .SETUP_CYCLES  (SETUP_CYCLES),
        .STROBE_CYCLES (STROBE_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES)
    ) u_cycle (
        .clock    (clock),
        .reset_n  (reset_n),
        .start_i  (bc_start),
        .phase_i  (bc_phase),
        .done_o   (bc_done),
        .rdata_o  (bc_rdata),
        .cs_n_o   (cs_n),
        .rd_n_o   (rd_n),
        .wr_n_o   (wr_n),
        .a_o      (a_pin),
        .do_o     (do_pin),
        .di_i     (bus.DI),
        .busy_n_i (bus.BUSY_n)
    );

    assign bus.CS_n       = cs_n;
    assign bus.RD_n       = rd_n;
    assign bus.WR_n       = wr_n;
    assign bus.A          = a_pin;
    assign bus.DO         = do_pin;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_status = rsp_status_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_vdc_bus_master.sv
// Directed bench: two masters (address cache on / off) driven in lockstep against
// a simple VDC model returning LSB=CD, MSB=AB, status=20.
module tb_vdc_bus_master;
    import huc6270_pkg::*;

    localparam int NLOG = 17;

    logic clock;
    logic reset_n;
    logic IRQ_n;
    logic irq0, irq1;
    int   total, bad;
    int   busy_len;
    int   bcnt0, bcnt1;

    logic [12:0] tr  [2][0:NLOG];
    logic        rv  [2][0:NLOG];
    logic        rdy [2][0:NLOG];

    vdc_bus_master_if b0 ();
    vdc_bus_master_if b1 ();

    vdc_bus_master #(.CACHE_ADDR(1'b1)) u_dut (
        .clock(clock), .reset_n(reset_n), .bus(b0), .IRQ_n(IRQ_n), .irq(irq0)
    );
    vdc_bus_master #(.CACHE_ADDR(1'b0)) u_dut_nc (
        .clock(clock), .reset_n(reset_n), .bus(b1), .IRQ_n(IRQ_n), .irq(irq1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // VDC model: read data by port select, BUSY_n low for the first busy_len strobe cycles
    assign b0.DI = (b0.A == A_DATA_LSB) ? 8'hCD : (b0.A == A_DATA_MSB) ? 8'hAB : 8'h20;
    assign b1.DI = (b1.A == A_DATA_LSB) ? 8'hCD : (b1.A == A_DATA_MSB) ? 8'hAB : 8'h20;
    always @(posedge clock) begin
        bcnt0 <= b0.RD_n ? 0 : bcnt0 + 1;
        bcnt1 <= b1.RD_n ? 0 : bcnt1 + 1;
    end
    assign b0.BUSY_n = !(!b0.RD_n && bcnt0 < busy_len);
    assign b1.BUSY_n = !(!b1.RD_n && bcnt1 < busy_len);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic v, input op_t op, input logic [4:0] rg, input logic [15:0] wd);
        b0.req_valid = v; b0.req_op = op; b0.req_reg = rg; b0.req_wdata = wd;
        b1.req_valid = v; b1.req_op = op; b1.req_reg = rg; b1.req_wdata = wd;
    endtask

    // Accept one request in cycle 0, scramble the inputs, then log cycles 1..NLOG.
    task automatic run_req(input op_t op, input logic [4:0] rg, input logic [15:0] wd);
        @(posedge clock); #1;
        set_req(1'b1, op, rg, wd);
        @(negedge clock);
        chk("accept ready", 32'({b0.req_ready, b1.req_ready}), 32'd3);
        @(posedge clock); #1;
        set_req(1'b0, OP_SEL, 5'h1F, 16'hDEAD);
        for (int c = 1; c <= NLOG; c++) begin
            @(negedge clock);
            tr[0][c]  = {b0.CS_n, b0.RD_n, b0.WR_n, b0.A, b0.DO};
            tr[1][c]  = {b1.CS_n, b1.RD_n, b1.WR_n, b1.A, b1.DO};
            rv[0][c]  = b0.rsp_valid;
            rv[1][c]  = b1.rsp_valid;
            rdy[0][c] = b0.req_ready;
            rdy[1][c] = b1.req_ready;
        end
    endtask

    // Default timing: each phase is S,St,St,H then a gap cycle; rsp in cycle 5*nph.
    task automatic check_run(input int i, input int nph, input logic [2:0] erd,
                             input logic [5:0] ea, input logic [23:0] ed, input string tag);
        int first, pulses, p, k;
        logic cs, stb;
        logic [12:0] ew, m;
        first = 0; pulses = 0;
        for (int c = 1; c <= NLOG; c++)
            if (rv[i][c]) begin
                pulses++;
                if (first == 0) first = c;
            end
        chk({tag, " rsp_cycle"}, 32'(first), 32'(5 * nph));
        chk({tag, " rsp_pulses"}, 32'(pulses), 32'd1);
        if (first > 0) chk({tag, " ready_at_rsp"}, 32'(rdy[i][first]), 32'd1);
        for (int c = 1; c <= 5 * nph; c++) begin
            p   = (c - 1) / 5;
            k   = (c - 1) % 5;
            cs  = (k == 4);
            stb = (k == 1 || k == 2);
            ew  = {cs, !(stb && erd[p]), !(stb && !erd[p]), ea[2*p +: 2], ed[8*p +: 8]};
            m   = cs ? 13'h1C00 : (erd[p] ? 13'h1F00 : 13'h1FFF);
            chk($sformatf("%s bus c%0d", tag, c), 32'(tr[i][c] & m), 32'(ew & m));
        end
    endtask

    initial begin
        int rd_low, first, seen;
        total = 0; bad = 0; busy_len = 0;
        reset_n = 1'b0; IRQ_n = 1'b1;
        set_req(1'b0, OP_SEL, 5'h00, 16'h0000);

        #12;
        chk("reset strobes", 32'({b0.CS_n, b0.RD_n, b0.WR_n}), 32'h7);
        chk("reset A/DO", 32'({b0.A, b0.DO}), 32'h0);
        chk("reset ready", 32'({b0.req_ready, b1.req_ready}), 32'h0);
        chk("reset rsp", 32'({b0.rsp_valid, b0.rsp_rdata, b0.rsp_status}), 32'h0);
        chk("reset irq", 32'(irq0), 32'd0);
        #10 reset_n = 1'b1;
        #1 chk("ready before first edge", 32'(b0.req_ready), 32'd0);
        @(posedge clock); #1;
        chk("ready after reset", 32'(b0.req_ready), 32'd1);

        // 1: write 0x1234 to VWR, cold cache
        run_req(OP_WR_REG, REG_VWR, 16'h1234);
        check_run(0, 3, 3'b000, {A_DATA_MSB, A_DATA_LSB, A_STATUS_ADDR_REG}, 24'h123402, "s1");
        check_run(1, 3, 3'b000, {A_DATA_MSB, A_DATA_LSB, A_STATUS_ADDR_REG}, 24'h123402, "s1nc");

        // 2/3: read VRR, hit skips select; no-cache instance re-selects
        run_req(OP_RD_REG, REG_VRR, 16'h0000);
        check_run(0, 2, 3'b011, {2'b00, A_DATA_MSB, A_DATA_LSB}, 24'h0, "s2");
        chk("s2 rdata", 32'(b0.rsp_rdata), 32'hABCD);
        check_run(1, 3, 3'b110, {A_DATA_MSB, A_DATA_LSB, A_STATUS_ADDR_REG}, 24'h000002, "s3nc");
        chk("s3 rdata", 32'(b1.rsp_rdata), 32'hABCD);

        // 4: status read stretched by BUSY_n
        busy_len = 5;
        run_req(OP_RD_STATUS, 5'h07, 16'h0000);
        busy_len = 0;
        rd_low = 0; first = 0;
        for (int c = 1; c <= NLOG; c++) begin
            if (!tr[0][c][11]) rd_low++;
            if (rv[0][c] && first == 0) first = c;
        end
        chk("s4 rd_low_cycles", 32'(rd_low), 32'd6);
        chk("s4 rsp_cycle", 32'(first), 32'd9);
        chk("s4 A during strobe", 32'(tr[0][2][9:8]), 32'(A_STATUS_ADDR_REG));
        chk("s4 status", 32'(b0.rsp_status), 32'h20);
        chk("s4 status nc", 32'(b1.rsp_status), 32'h20);
        chk("s4 rdata held", 32'(b0.rsp_rdata), 32'hABCD);

        // status read left the cache on VRR
        run_req(OP_RD_REG, REG_VRR, 16'h0000);
        check_run(0, 2, 3'b011, {2'b00, A_DATA_MSB, A_DATA_LSB}, 24'h0, "s4b");

        // 5: reset during the LSB strobe (phase 0 on the cached instance)
        @(posedge clock); #1;
        set_req(1'b1, OP_WR_REG, REG_VWR, 16'h5678);
        @(posedge clock); #1;
        set_req(1'b0, OP_SEL, 5'h00, 16'h0000);
        @(posedge clock); #2;
        chk("s5 in strobe", 32'({b0.WR_n, b0.A}), 32'({1'b0, A_DATA_LSB}));
        reset_n = 1'b0;
        #1;
        chk("s5 strobes released", 32'({b0.CS_n, b0.WR_n, b1.CS_n, b1.WR_n}), 32'hF);
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (b0.rsp_valid || b1.rsp_valid) seen++;
        end
        chk("s5 no rsp", 32'(seen), 32'd0);
        chk("s5 rdata reset", 32'(b0.rsp_rdata), 32'h0);
        run_req(OP_WR_REG, REG_VWR, 16'h1234);
        check_run(0, 3, 3'b000, {A_DATA_MSB, A_DATA_LSB, A_STATUS_ADDR_REG}, 24'h123402, "s5");

        // 6: IRQ_n low for three cycles
        @(posedge clock); #1 IRQ_n = 1'b0;
        @(posedge clock); #1 chk("s6 irq e1", 32'(irq0), 32'd0);
        @(posedge clock); #1 chk("s6 irq e2", 32'(irq0), 32'd1);
        @(posedge clock); #1 IRQ_n = 1'b1;
        @(posedge clock); #1 chk("s6 irq e4", 32'(irq0), 32'd1);
        @(posedge clock); #1 chk("s6 irq e5", 32'(irq0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vdc_bus_master.md
Name: vdc_bus_master

Overview:
- CPU-side initiator for the HuC6270 VDC host port. It drives CS_n/RD_n/WR_n/A/DO and samples DI/BUSY_n.
- Converts one 16-bit register request into the byte-wide bus-cycle sequence the VDC control unit responds to:
  - address-register select (A=00);
  - data LSB (A=10);
  - data MSB (A=11).
- Sits between the CPU core/test harness and the VDC control unit. It also synchronizes IRQ_n.

Parameters:
- SETUP_CYCLES, 1: cycles CS_n/A/DO are valid before the strobe asserts (min 1).
- STROBE_CYCLES, 2: minimum cycles RD_n/WR_n is held low (min 1).
- HOLD_CYCLES, 1: cycles CS_n/A/DO are held after the strobe deasserts (min 1).
- CACHE_ADDR, 1: when 1, skip the address-select bus cycle if req_reg equals the cached address-register value.

Ports:
- clock, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: block is in IDLE and can accept a request.
- req_op, input, 2 (op_t): OP_SEL, OP_WR_REG, OP_RD_REG, OP_RD_STATUS.
- req_reg, input, 5: VDC register number (addr_reg_t).
- req_wdata, input, 16: write data for OP_WR_REG.
- rsp_valid, output, 1: one-cycle completion pulse.
- rsp_rdata, output, 16: {MSB,LSB} for OP_RD_REG; otherwise holds its previous value.
- rsp_status, output, 8: status byte from OP_RD_STATUS.
- irq, output, 1: active-high, 2-flop-synchronized inversion of IRQ_n.
- CS_n, RD_n, WR_n, output, 1 each: VDC bus strobes.
- A, output, 2 (a_sel_t): VDC port select.
- DO, output, 8: write data to the VDC.
- DI, input, 8: read data from the VDC.
- BUSY_n, input, 1: wait request from the VDC; low extends the strobe.
- IRQ_n, input, 1: VDC interrupt, asynchronous.

Behaviour:
- Reset values (asynchronous, while reset_n low):
  - CS_n=RD_n=WR_n=1, A=A_STATUS_ADDR_REG, DO=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_status=0, irq=0.
  - Address cache invalid; FSM in IDLE.
  - Reset mid-sequence aborts it with no response and leaves no partial strobe.
  - req_ready=1 from the first cycle after reset_n rises.
- FSM states: IDLE, SETUP, STROBE, HOLD, GAP.
  - IDLE -> SETUP on req_valid&req_ready.
  - SETUP -> STROBE after SETUP_CYCLES.
  - STROBE -> HOLD once STROBE_CYCLES have elapsed AND BUSY_n is sampled high in the last cycle.
    - BUSY_n low extends STROBE indefinitely; there is no timeout.
  - HOLD -> GAP when phases remain; GAP lasts 1 cycle with CS_n=1, then -> SETUP.
  - HOLD -> IDLE on the last phase.
- Signal levels by state:
  - CS_n=0 in SETUP, STROBE and HOLD.
  - RD_n or WR_n=0 only in STROBE.
  - A and DO are stable across SETUP..HOLD of one phase.
- Phase lists, latched at acceptance:
  - OP_SEL: W(A=00, DO=req_reg zero-extended).
  - OP_WR_REG: [W(00, reg)], W(10, wdata[7:0]), W(11, wdata[15:8]).
  - OP_RD_REG: [W(00, reg)], R(10), R(11).
  - OP_RD_STATUS: R(00).
  - [ ] marks a phase omitted on a cache hit (CACHE_ADDR=1, cache valid, req_reg==cache).
  - OP_SEL is never skipped.
- Read capture: DI is sampled at the clock edge ending the final STROBE cycle. LSB and MSB go into a holding register; rsp_rdata/rsp_status update together with rsp_valid.
- Address cache: loaded with req_reg on completion of any W(00) phase. OP_RD_STATUS does not alter it.
- Completion:
  - rsp_valid=1 for exactly the first IDLE cycle after the final HOLD.
  - req_ready=1 in that same cycle, so back-to-back acceptance is allowed.
- Request inputs are ignored unless req_ready=1. Latched request fields are immune to input changes mid-sequence.
- Unused A=01 is never driven.
- Latency with defaults, BUSY_n high, accept edge ending cycle 0:
  - 3-phase operation: rsp_valid in cycle 15.
  - 2-phase operation: cycle 10.
  - 1-phase operation: cycle 5.

Decomposition:
- Shared package huc6270_pkg:
  - a_sel_t (A_STATUS_ADDR_REG=2'b00, A_DATA_LSB=2'b10, A_DATA_MSB=2'b11);
  - addr_reg_t (5-bit);
  - op_t;
  - VDC register number constants (MAWR=0x00, MARR=0x01, VRR/VWR=0x02, …).
- One sub-module: vdc_bus_cycle, which owns a single phase's SETUP/STROBE/HOLD timing, BUSY_n extension and DI capture. The top level holds the phase sequencer, address cache, response registers and IRQ synchronizer.

Test Plan:
1. After reset, OP_WR_REG reg=0x02 wdata=0x1234 with BUSY_n high:
   - bus shows W(00, 0x02), W(10, 0x34), W(11, 0x12);
   - each WR_n low for 2 cycles, CS_n high for 1 cycle between phases;
   - rsp_valid in cycle 15.
2. OP_RD_REG reg=0x02 immediately after scenario 1, with the VDC model returning 0xCD then 0xAB:
   - no A=00 cycle (cache hit);
   - rsp_rdata=0xABCD in cycle 10.
3. Same as scenario 2 with CACHE_ADDR=0: the A=00 write reappears and rsp_valid arrives in cycle 15.
4. OP_RD_STATUS with BUSY_n held low for 5 cycles from strobe start:
   - RD_n low for 6 cycles;
   - DI=0x20 captured; rsp_status=0x20.
5. Assert reset_n low during the STROBE of the LSB phase:
   - CS_n/WR_n high immediately; no rsp_valid;
   - the following OP_WR_REG reg=0x02 re-issues the A=00 cycle (cache invalidated).
6. Toggle IRQ_n low for 3 cycles: irq goes high 2 cycles later and returns low 2 cycles after IRQ_n rises.
